// File: rtl/ad_ip_jesd204_tpl_adc_pkg.sv
// Shared definitions for the JESD204 ADC transport-layer PN checker:
// sequence select codes, PRBS taps and the per-channel sync FSM states.
package ad_ip_jesd204_tpl_adc_pkg;

    localparam logic [3:0] PN_SEL_PN9  = 4'h0;
    localparam logic [3:0] PN_SEL_PN23 = 4'h1;

    localparam int unsigned PN9_TAP_A  = 9;
    localparam int unsigned PN9_TAP_B  = 5;
    localparam int unsigned PN23_TAP_A = 23;
    localparam int unsigned PN23_TAP_B = 18;

    localparam int unsigned PN_HIST_W  = 23;

    typedef enum logic {
        OOS  = 1'b0,
        SYNC = 1'b1
    } pn_state_e;

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pn_chan.sv
// One channel of the PN checker: history, self-synchronising expected bits,
// OOS/SYNC FSM. Optional error counter under TPL_ADC_PN_ERR_COUNT_EN.
module ad_ip_jesd204_tpl_adc_pn_chan
    import ad_ip_jesd204_tpl_adc_pkg::*;
#(
    parameter int unsigned CONVERTER_RESOLUTION = 16,
    parameter int unsigned DATA_PATH_WIDTH      = 1,
    parameter int unsigned OOS_THRESHOLD        = 16
) (
    input  logic                                           link_clk,
    input  logic                                           link_resetn,
    input  logic                                           data_valid,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] data,
    input  logic [3:0]                                     pn_seq_sel,
`ifdef TPL_ADC_PN_ERR_COUNT_EN
    input  logic                                           pn_err_count_clr,
    output logic [15:0]                                    pn_err_count,
`endif
    output logic                                           pn_err,
    output logic                                           pn_oos
);

    localparam int unsigned W         = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
    localparam logic [4:0]  FILL_FULL = 5'(PN_HIST_W);
    localparam logic [7:0]  THR       = 8'(OOS_THRESHOLD);

    logic [W-1:0]           stream;
    logic [W-1:0]           rx_sr;
    logic                   rx_bit;
    logic                   exp_bit;

    logic [3:0]             sel_q;
    logic                   sel_init_q;
    logic                   sel_chg;
    logic                   sel_en;
    logic                   is_pn23;
    logic                   accept;
    logic [4:0]             fill_need;

    logic [PN_HIST_W-1:0]   hist_q, hist_d;
    logic [4:0]             fill_q, fill_d;
    logic                   mis_d;
    logic                   s1_vld_q, s1_mis_q;

    pn_state_e              state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             cnt_inc;
    logic                   err_q, err_d;
    logic                   oos_q;

    // Serial order: sample 0 first, each sample MSB first; stream[0] is checked first.
    for (genvar j = 0; j < W; j++) begin : g_order
        assign stream[j] = data[(j / CONVERTER_RESOLUTION) * CONVERTER_RESOLUTION +
                                (CONVERTER_RESOLUTION - 1 - (j % CONVERTER_RESOLUTION))];
    end

    assign sel_chg   = sel_init_q && (pn_seq_sel != sel_q);
    assign is_pn23   = (pn_seq_sel == PN_SEL_PN23);
    assign sel_en    = (pn_seq_sel == PN_SEL_PN9) || is_pn23;
    assign accept    = data_valid && sel_en && !sel_chg;
    assign fill_need = is_pn23 ? 5'(PN23_TAP_A) : 5'(PN9_TAP_A);

    // Bits whose taps still reach into cleared history are not compared, so a
    // clean stream matches from its very first beat.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        mis_d   = 1'b0;
        rx_sr   = stream;
        rx_bit  = 1'b0;
        exp_bit = 1'b0;
        for (int unsigned j = 0; j < W; j++) begin
            rx_bit  = rx_sr[0];
            rx_sr   = rx_sr >> 1;
            exp_bit = is_pn23 ? (hist_d[PN23_TAP_A-1] ^ hist_d[PN23_TAP_B-1])
                              : (hist_d[PN9_TAP_A-1]  ^ hist_d[PN9_TAP_B-1]);
            if ((fill_d >= fill_need) && (rx_bit != exp_bit)) begin
                mis_d = 1'b1;
            end
            hist_d = {hist_d[PN_HIST_W-2:0], (state_q == SYNC) ? exp_bit : rx_bit};
            if (fill_d != FILL_FULL) begin
                fill_d = fill_d + 5'd1;
            end
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            sel_q      <= '0;
            sel_init_q <= 1'b0;
            hist_q     <= '0;
            fill_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_mis_q   <= 1'b0;
        end else begin
            sel_q      <= pn_seq_sel;
            sel_init_q <= 1'b1;
            if (sel_chg) begin
                hist_q   <= '0;
                fill_q   <= '0;
                s1_vld_q <= 1'b0;
                s1_mis_q <= 1'b0;
            end else begin
                s1_vld_q <= accept;
                s1_mis_q <= accept && mis_d;
                if (accept) begin
                    hist_q <= hist_d;
                    fill_q <= fill_d;
                end
            end
        end
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (sel_chg || !sel_en) begin
            state_d = OOS;
            cnt_d   = '0;
        end else if (s1_vld_q) begin
            case (state_q)
                OOS: begin
                    if (s1_mis_q) begin
                        cnt_d = '0;
                    end else if (cnt_inc == THR) begin
                        state_d = SYNC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                SYNC: begin
                    err_d = s1_mis_q;
                    if (!s1_mis_q) begin
                        cnt_d = '0;
                    end else if (cnt_inc == THR) begin
                        state_d = OOS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = OOS;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            state_q <= OOS;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            oos_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            oos_q   <= (state_d == OOS);
        end
    end

    assign pn_err = err_q;
    assign pn_oos = oos_q;

`ifdef TPL_ADC_PN_ERR_COUNT_EN
    logic [15:0] ecnt_q, ecnt_d;

    always_comb begin
        ecnt_d = ecnt_q;
        if (pn_err_count_clr || sel_chg) begin
            ecnt_d = '0;
        end else if (err_d && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + 16'd1;
        end
    end

    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign pn_err_count = ecnt_q;
`endif

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pn_check.sv
// Per-channel PN9/PN23 checker for the JESD204 ADC transport layer.
// Define TPL_ADC_PN_ERR_COUNT_EN to add per-channel saturating error counters.
module ad_ip_jesd204_tpl_adc_pn_check #(
    parameter int unsigned NUM_CHANNELS         = 1,
    parameter int unsigned CONVERTER_RESOLUTION = 16,
    parameter int unsigned DATA_PATH_WIDTH      = 1,
    parameter int unsigned OOS_THRESHOLD        = 16
) (
    input  logic                                                        link_clk,
    input  logic                                                        link_resetn,
    input  logic                                                        data_valid,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] data,
    input  logic [NUM_CHANNELS*4-1:0]                                   pn_seq_sel,
`ifdef TPL_ADC_PN_ERR_COUNT_EN
    input  logic [NUM_CHANNELS-1:0]                                     pn_err_count_clr,
    output logic [NUM_CHANNELS*16-1:0]                                  pn_err_count,
`endif
    output logic [NUM_CHANNELS-1:0]                                     pn_err,
    output logic [NUM_CHANNELS-1:0]                                     pn_oos
);

    localparam int unsigned W = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        ad_ip_jesd204_tpl_adc_pn_chan #(
            .CONVERTER_RESOLUTION (CONVERTER_RESOLUTION),
            .DATA_PATH_WIDTH      (DATA_PATH_WIDTH),
            .OOS_THRESHOLD        (OOS_THRESHOLD)
        ) i_chan (
            .link_clk         (link_clk),
            .link_resetn      (link_resetn),
            .data_valid       (data_valid),
            .data             (data[c*W +: W]),
            .pn_seq_sel       (pn_seq_sel[c*4 +: 4]),
`ifdef TPL_ADC_PN_ERR_COUNT_EN
            .pn_err_count_clr (pn_err_count_clr[c]),
            .pn_err_count     (pn_err_count[c*16 +: 16]),
`endif
            .pn_err           (pn_err[c]),
            .pn_oos           (pn_oos[c])
        );
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_check.sv
// Directed bench for the PN checker: 2 channels, 2 x 16-bit samples per beat,
// threshold 16. Exercises the counter too when TPL_ADC_PN_ERR_COUNT_EN is defined.
module tb_ad_ip_jesd204_tpl_adc_pn_check;

    localparam int unsigned NCH = 2;
    localparam int unsigned RES = 16;
    localparam int unsigned DPW = 2;
    localparam int unsigned THR = 16;

    logic            link_clk = 1'b0;
    logic            link_resetn = 1'b0;
    logic            data_valid = 1'b0;
    logic [63:0]     data = '0;
    logic [7:0]      pn_seq_sel = 8'h70;
    logic [1:0]      pn_err;
    logic [1:0]      pn_oos;
`ifdef TPL_ADC_PN_ERR_COUNT_EN
    logic [1:0]      pn_err_count_clr = '0;
    logic [31:0]     pn_err_count;
`endif

    int              n_checks = 0;
    int              n_fail   = 0;

    logic [7:0]      sel_next = 8'h70;
    logic [1:0]      clr_next = '0;
    logic            ch0_rand = 1'b0;
    logic [22:0]     g0 = 23'h1;
    logic [22:0]     g1 = 23'h1;

    always #5 link_clk = ~link_clk;

    ad_ip_jesd204_tpl_adc_pn_check #(
        .NUM_CHANNELS         (NCH),
        .CONVERTER_RESOLUTION (RES),
        .DATA_PATH_WIDTH      (DPW),
        .OOS_THRESHOLD        (THR)
    ) dut (
        .link_clk         (link_clk),
        .link_resetn      (link_resetn),
        .data_valid       (data_valid),
        .data             (data),
        .pn_seq_sel       (pn_seq_sel),
`ifdef TPL_ADC_PN_ERR_COUNT_EN
        .pn_err_count_clr (pn_err_count_clr),
        .pn_err_count     (pn_err_count),
`endif
        .pn_err           (pn_err),
        .pn_oos           (pn_oos)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // PRBS generator: st[0] is the newest bit; 32 bits emitted, sample 0 first, MSB first.
    task automatic gen_beat(input logic pn23, input logic [22:0] st_i,
                            output logic [22:0] st_o, output logic [31:0] w);
        logic [22:0] st;
        logic        nb;
        st = st_i;
        w  = '0;
        for (int j = 0; j < 32; j++) begin
            nb = pn23 ? (st[22] ^ st[17]) : (st[8] ^ st[4]);
            st = {st[21:0], nb};
            w[(j / 16) * 16 + 15 - (j % 16)] = nb;
        end
        st_o = st;
    endtask

    // One clock: drive inputs just after the rising edge, return at the falling edge.
    // Outputs seen on return reflect the beat driven two calls earlier.
    task automatic cycle_beat(input logic v, input logic [1:0] flip);
        logic [31:0] w0, w1;
        @(posedge link_clk);
        #1;
        w0 = '0;
        w1 = '0;
        if (v) begin
            if (ch0_rand) w0 = $urandom();
            else          gen_beat(1'b0, g0, g0, w0);
            gen_beat(1'b1, g1, g1, w1);
        end
        w0[0] = w0[0] ^ flip[0];
        w1[0] = w1[0] ^ flip[1];
        data       = {w1, w0};
        data_valid = v;
        pn_seq_sel = sel_next;
`ifdef TPL_ADC_PN_ERR_COUNT_EN
        pn_err_count_clr = clr_next;
`endif
        @(negedge link_clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fall;
        logic seen_err, seen_sync;

        // Reset state
        repeat (3) @(negedge link_clk);
        check("rst_oos", pn_oos, 2'b11);
        check("rst_err", pn_err, 2'b00);
`ifdef TPL_ADC_PN_ERR_COUNT_EN
        check("rst_cnt", pn_err_count, 32'h0);
`endif
        @(posedge link_clk);
        #1 link_resetn = 1'b1;
        cycle_beat(1'b0, 2'b00);
        cycle_beat(1'b0, 2'b00);
        check("idle_oos", pn_oos, 2'b11);

        // Clean PN9 on ch0 (ch1 disabled): pn_oos[0] falls 17 cycles after beat 0
        fall = -1;
        seen_err = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cycle_beat(1'b1, 2'b00);
            if (pn_oos[0] == 1'b0 && fall < 0) fall = c;
            if (pn_err != 2'b00) seen_err = 1'b1;
        end
        check("pn9_sync_lat", fall, 17);
        check("pn9_no_err", seen_err, 1'b0);
        check("pn9_oos", pn_oos, 2'b10);

        // Single-bit error in sync: one pulse two cycles later
        cycle_beat(1'b1, 2'b01);
        cycle_beat(1'b1, 2'b00);
        check("flip_err_t1", pn_err[0], 1'b0);
        cycle_beat(1'b1, 2'b00);
        check("flip_err_t2", pn_err[0], 1'b1);
        check("flip_oos_t2", pn_oos[0], 1'b0);
        cycle_beat(1'b1, 2'b00);
        check("flip_err_t3", pn_err[0], 1'b0);

        // 16 corrupted beats: sync survives 15, lost on the 16th
        for (int k = 0; k < 16; k++) cycle_beat(1'b1, 2'b01);
        cycle_beat(1'b1, 2'b00);
        check("bad15_oos", pn_oos[0], 1'b0);
        check("bad15_err", pn_err[0], 1'b1);
        cycle_beat(1'b1, 2'b00);
        check("bad16_oos", pn_oos[0], 1'b1);

        // PN23 on ch1 (select changes on the first beat, which is dropped); ch0 random
        ch0_rand  = 1'b1;
        sel_next  = 8'h10;
        fall      = -1;
        seen_err  = 1'b0;
        seen_sync = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cycle_beat(1'b1, 2'b00);
            if (pn_oos[1] == 1'b0 && fall < 0) fall = c;
            if (pn_oos[0] == 1'b0) seen_sync = 1'b1;
            if (pn_err != 2'b00) seen_err = 1'b1;
        end
        check("pn23_sync_lat", fall, 18);
        check("rand_no_sync", seen_sync, 1'b0);
        check("rand_no_err", seen_err, 1'b0);

        // Cycles without data_valid hold state and keep pn_err low
        for (int c = 0; c < 4; c++) cycle_beat(1'b0, 2'b00);
        check("hold_oos", pn_oos, 2'b01);
        check("hold_err", pn_err, 2'b00);

`ifdef TPL_ADC_PN_ERR_COUNT_EN
        check("cnt_start", pn_err_count[31:16], 32'h0);
        for (int p = 0; p < 3; p++) begin
            cycle_beat(1'b1, 2'b10);
            cycle_beat(1'b1, 2'b00);
        end
        cycle_beat(1'b1, 2'b00);
        cycle_beat(1'b1, 2'b00);
        check("cnt_three", pn_err_count[31:16], 32'd3);
        cycle_beat(1'b1, 2'b10);
        clr_next = 2'b10;
        cycle_beat(1'b1, 2'b00);
        check("cnt_pre_clr", pn_err_count[31:16], 32'd3);
        clr_next = 2'b00;
        cycle_beat(1'b1, 2'b00);
        check("clr_pulse_err", pn_err[1], 1'b1);
        check("clr_wins", pn_err_count[31:16], 32'd0);
        for (int g = 0; g < 4667; g++) begin
            for (int k = 0; k < 15; k++) cycle_beat(1'b1, 2'b10);
            cycle_beat(1'b1, 2'b00);
        end
        cycle_beat(1'b1, 2'b00);
        cycle_beat(1'b1, 2'b00);
        check("cnt_sat", pn_err_count[31:16], 32'hFFFF);
        check("sat_still_sync", pn_oos[1], 1'b0);
`endif

        // Resync ch0 on PN9, then switch it to PN23 with the stream still PN9
        ch0_rand = 1'b0;
        for (int c = 0; c < 25; c++) cycle_beat(1'b1, 2'b00);
        check("resync_oos", pn_oos, 2'b00);
        sel_next = 8'h11;
        cycle_beat(1'b1, 2'b00);
        check("selchg_before", pn_oos[0], 1'b0);
        cycle_beat(1'b1, 2'b00);
        check("selchg_oos", pn_oos[0], 1'b1);
        seen_sync = 1'b0;
        seen_err  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cycle_beat(1'b1, 2'b00);
            if (pn_oos[0] == 1'b0) seen_sync = 1'b1;
            if (pn_err[0]) seen_err = 1'b1;
        end
        check("wrong_seq_no_sync", seen_sync, 1'b0);
        check("wrong_seq_no_err", seen_err, 1'b0);
        check("ch1_kept_sync", pn_oos[1], 1'b0);

        // Disabled select on ch0
        sel_next = 8'h17;
        seen_err = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle_beat(1'b1, 2'b01);
            if (pn_err[0]) seen_err = 1'b1;
        end
        check("dis_oos", pn_oos[0], 1'b1);
        check("dis_err", seen_err, 1'b0);

        // Asynchronous reset mid-sync, between clock edges
        @(negedge link_clk);
        #2 link_resetn = 1'b0;
        #1;
        check("async_rst_oos", pn_oos, 2'b11);
        check("async_rst_err", pn_err, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
